// File: rtl/multicycle_main_fsm_pkg.sv
// Shared definitions for the multicycle RV32I control path: state encoding,
// opcode constants and the mux-select / AluOp encodings used by the datapath.
package multicycle_main_fsm_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives datapath selects and strobes.
module multicycle_main_fsm
    import multicycle_main_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] AluOp,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic       InstrDone
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic       w_regwrite;
    logic       w_illegal;
    logic       w_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore output decode (MemReady gates the memory-state strobes)
    always_comb begin
        w_next      = S_FETCH;
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_resultsrc = RES_ALUOUT;
        w_alusrca   = SRCA_PC;
        w_alusrcb   = SRCB_RD2;
        w_aluop     = ALUOP_ADD;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrca   = SRCA_PC;
                w_alusrcb   = SRCB_FOUR;
                w_resultsrc = RES_ALURESULT;
                w_irwrite   = MemReady;
                w_pcupdate  = MemReady;
                w_next      = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrca = SRCA_OLDPC;
                w_alusrcb = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                        w_done    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = SRCA_RD1;
                w_alusrcb = SRCB_IMM;
                w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_resultsrc = RES_DATA;
                w_regwrite  = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_done     = MemReady;
                w_next     = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                w_alusrca = SRCA_RD1;
                w_alusrcb = SRCB_RD2;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alusrca = SRCA_RD1;
                w_alusrcb = SRCB_IMM;
                w_aluop   = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_JAL: begin
                w_alusrca  = SRCA_OLDPC;
                w_alusrcb  = SRCB_FOUR;
                w_pcupdate = 1'b1;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                w_alusrca = SRCA_RD1;
                w_alusrcb = SRCB_RD2;
                w_aluop   = ALUOP_SUB;
                w_branch  = 1'b1;
                w_done    = 1'b1;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks every output so nothing fires while the core is held
    assign PCWrite   = ~reset & (w_pcupdate | (w_branch & Zero));
    assign AdrSrc    = ~reset & w_adrsrc;
    assign MemWrite  = ~reset & w_memwrite;
    assign IRWrite   = ~reset & w_irwrite;
    assign ResultSrc = reset ? 2'b00 : w_resultsrc;
    assign ALUSrcA   = reset ? 2'b00 : w_alusrca;
    assign ALUSrcB   = reset ? 2'b00 : w_alusrcb;
    assign AluOp     = reset ? 2'b00 : w_aluop;
    assign RegWrite  = ~reset & w_regwrite;
    assign IllegalOp = ~reset & w_illegal;
    assign InstrDone = ~reset & w_done;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: per-cycle output vectors checked
// against hand-derived expectations for each instruction class.
module tb_multicycle_main_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] AluOp;
    logic       RegWrite;
    logic       IllegalOp;
    logic       InstrDone;

    int n_pass;
    int n_total;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,AluOp,RegWrite,IllegalOp,InstrDone}
    logic [14:0] w_out;
    assign w_out = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, AluOp, RegWrite, IllegalOp, InstrDone};

    localparam logic [14:0] V_ZERO  = 15'b0_0_0_0_00_00_00_00_0_0_0;
    localparam logic [14:0] V_FR    = 15'b1_0_0_1_10_00_10_00_0_0_0;
    localparam logic [14:0] V_FNR   = 15'b0_0_0_0_10_00_10_00_0_0_0;
    localparam logic [14:0] V_DEC   = 15'b0_0_0_0_00_01_01_00_0_0_0;
    localparam logic [14:0] V_DECIL = 15'b0_0_0_0_00_01_01_00_0_1_1;
    localparam logic [14:0] V_MADR  = 15'b0_0_0_0_00_10_01_00_0_0_0;
    localparam logic [14:0] V_MRD   = 15'b0_1_0_0_00_00_00_00_0_0_0;
    localparam logic [14:0] V_MWB   = 15'b0_0_0_0_01_00_00_00_1_0_1;
    localparam logic [14:0] V_MWRW  = 15'b0_1_1_0_00_00_00_00_0_0_0;
    localparam logic [14:0] V_MWRD  = 15'b0_1_1_0_00_00_00_00_0_0_1;
    localparam logic [14:0] V_EXR   = 15'b0_0_0_0_00_10_00_10_0_0_0;
    localparam logic [14:0] V_EXI   = 15'b0_0_0_0_00_10_01_10_0_0_0;
    localparam logic [14:0] V_JAL   = 15'b1_0_0_0_00_01_10_00_0_0_0;
    localparam logic [14:0] V_AWB   = 15'b0_0_0_0_00_00_00_00_1_0_1;
    localparam logic [14:0] V_BEQT  = 15'b1_0_0_0_00_10_00_01_0_0_1;
    localparam logic [14:0] V_BEQN  = 15'b0_0_0_0_00_10_00_01_0_0_1;

    multicycle_main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .AluOp     (AluOp),
        .RegWrite  (RegWrite),
        .IllegalOp (IllegalOp),
        .InstrDone (InstrDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        op = 7'b0110011; MemReady = 1'b1; Zero = 1'b0; reset = 1'b1;
        #2;
        n_total++;
        if (w_out !== V_ZERO) $display("FAIL reset_async: got %b expected %b", w_out, V_ZERO);
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        n_total++;
        if (w_out !== V_ZERO) $display("FAIL reset_held: got %b expected %b", w_out, V_ZERO);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (w_out !== V_FR) $display("FAIL reset_release_fetch: got %b expected %b", w_out, V_FR);
        else n_pass++;
        // finish the R-type already under way to return to FETCH
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_rtype();
        logic [14:0] exp_v [5];
        exp_v = '{V_FR, V_DEC, V_EXR, V_AWB, V_FR};
        op = 7'b0110011; MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_total++;
            if (w_out !== exp_v[i]) $display("FAIL rtype cycle %0d: got %b expected %b", i, w_out, exp_v[i]);
            else n_pass++;
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_itype();
        logic [14:0] exp_v [4];
        exp_v = '{V_FR, V_DEC, V_EXI, V_AWB};
        op = 7'b0010011; MemReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_total++;
            if (w_out !== exp_v[i]) $display("FAIL itype cycle %0d: got %b expected %b", i, w_out, exp_v[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_stall();
        logic [14:0] exp_v [10];
        logic        rdy [10];
        exp_v = '{V_FNR, V_FNR, V_FR, V_DEC, V_MADR, V_MRD, V_MRD, V_MRD, V_MRD, V_MWB};
        // ready is dropped in DECODE/MEMADR/MEMWB where it must be ignored
        rdy   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op = 7'b0000011;
        for (int i = 0; i < 10; i++) begin
            MemReady = rdy[i];
            #1;
            n_total++;
            if (w_out !== exp_v[i]) $display("FAIL lw cycle %0d: got %b expected %b", i, w_out, exp_v[i]);
            else n_pass++;
            @(posedge clk); #1;
        end
        MemReady = 1'b1;
        #1;
        n_total++;
        if (w_out !== V_FR) $display("FAIL lw_return: got %b expected %b", w_out, V_FR);
        else n_pass++;
    endtask

    task automatic test_sw_stall();
        logic [14:0] exp_v [7];
        logic        rdy [7];
        exp_v = '{V_FR, V_DEC, V_MADR, V_MWRW, V_MWRW, V_MWRD, V_FR};
        rdy   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        op = 7'b0100011;
        for (int i = 0; i < 7; i++) begin
            MemReady = rdy[i];
            #1;
            n_total++;
            if (w_out !== exp_v[i]) $display("FAIL sw cycle %0d: got %b expected %b", i, w_out, exp_v[i]);
            else n_pass++;
            if (i < 6) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_beq();
        logic [14:0] exp_v [4];
        op = 7'b1100011; MemReady = 1'b1;
        for (int z = 1; z >= 0; z--) begin
            Zero = z[0];
            exp_v = '{V_FR, V_DEC, (z == 1) ? V_BEQT : V_BEQN, V_FR};
            for (int i = 0; i < 4; i++) begin
                #1;
                n_total++;
                if (w_out !== exp_v[i]) $display("FAIL beq_zero%0d cycle %0d: got %b expected %b", z, i, w_out, exp_v[i]);
                else n_pass++;
                if (i < 3) begin
                    @(posedge clk); #1;
                end
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_illegal_and_jal();
        logic [14:0] exp_v [7];
        logic [6:0]  ops [7];
        exp_v = '{V_FR, V_DECIL, V_FR, V_DEC, V_JAL, V_AWB, V_FR};
        ops   = '{7'b1111111, 7'b1111111, 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
        MemReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            op = ops[i];
            #1;
            n_total++;
            if (w_out !== exp_v[i]) $display("FAIL illegal_jal cycle %0d: got %b expected %b", i, w_out, exp_v[i]);
            else n_pass++;
            if (i < 6) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_mid_reset();
        op = 7'b0110011; MemReady = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_total++;
        if (w_out !== V_EXR) $display("FAIL midreset_pre: got %b expected %b", w_out, V_EXR);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (w_out !== V_ZERO) $display("FAIL midreset_abort: got %b expected %b", w_out, V_ZERO);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (w_out !== V_ZERO) $display("FAIL midreset_held: got %b expected %b", w_out, V_ZERO);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (w_out !== V_FR) $display("FAIL midreset_restart: got %b expected %b", w_out, V_FR);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        op = 7'b0110011;
        Zero = 1'b0;
        MemReady = 1'b1;
        test_reset();
        test_rtype();
        test_itype();
        test_lw_stall();
        test_sw_stall();
        test_beq();
        test_illegal_and_jal();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Main control FSM for the multicycle RV32I datapath; sits directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives datapath mux selects and write strobes, plus the 2-bit AluOp consumed by the ALU decoder.
- Stalls fetch and data-memory states on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of the state register (11 states used).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- op  input  7  instruction opcode field, instr[6:0], taken from the instruction register
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory has completed the current access this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- MemWrite  output  1  data memory write strobe
- IRWrite  output  1  instruction register and OldPC enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  output  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- AluOp  output  2  00 = add, 01 = sub (beq), 10 = use funct fields
- RegWrite  output  1  register file write enable
- IllegalOp  output  1  one-cycle pulse when an unsupported opcode is decoded
- InstrDone  output  1  one-cycle pulse on the final cycle of each instruction

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
  - Reset sets state = FETCH.
  - While reset is high, all strobes are forced to 0: PCWrite, MemWrite, IRWrite, RegWrite, IllegalOp, InstrDone.
  - While reset is high, all selects and AluOp read as 00 (AdrSrc = 0).
- Output style:
  - Outputs are Moore decode of state, except where a line below gates a strobe with MemReady.
  - Any signal not listed for a state is 0.
  - PCWrite = PCUpdate | (Branch & Zero), where PCUpdate and Branch are internal.
- States (output settings -> next state):
  - FETCH: AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, AluOp = 00, ResultSrc = 10; IRWrite = PCUpdate = MemReady. Stay while !MemReady; else -> DECODE.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01, AluOp = 00 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other opcode -> FETCH, with IllegalOp = 1 and InstrDone = 1
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01, AluOp = 00. op = 0000011 -> MEMREAD; else -> MEMWRITE.
  - MEMREAD: AdrSrc = 1, ResultSrc = 00. Stay while !MemReady; else -> MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite = 1, InstrDone = 1 -> FETCH.
  - MEMWRITE: AdrSrc = 1, ResultSrc = 00, MemWrite = 1, held for the whole wait. Stay while !MemReady; else -> FETCH with InstrDone = 1 on that cycle.
  - EXECUTER: ALUSrcA = 10, ALUSrcB = 00, AluOp = 10 -> ALUWB.
  - EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, AluOp = 10 -> ALUWB.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, AluOp = 00, ResultSrc = 00, PCUpdate = 1 -> ALUWB.
  - ALUWB: ResultSrc = 00, RegWrite = 1, InstrDone = 1 -> FETCH.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, AluOp = 01, ResultSrc = 00, Branch = 1, InstrDone = 1 -> FETCH.
- Latency with MemReady = 1:
  - beq: 3 cycles
  - R-type, I-type ALU, sw: 4 cycles
  - jal: 4 cycles
  - lw: 5 cycles
- Boundary conditions:
  - Unused state encodings -> FETCH.
  - MemReady is ignored in every state except FETCH, MEMREAD and MEMWRITE.
  - The op input is sampled only in DECODE and MEMADR.
  - Reset asserted mid-instruction aborts the instruction immediately; no strobe fires after reset is asserted.

Decomposition:
- Shared package holds:
  - state enum
  - opcode constants (OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ)
  - ResultSrc, ALUSrcA, ALUSrcB and AluOp encodings, shared with the ALU decoder and datapath
- No sub-module: state register, next-state logic and output decode live in one module.

Test Plan:
- Reset with op = 0110011, MemReady = 1 -> state FETCH, all strobes 0. First cycle after release: IRWrite = 1, PCWrite = 1, ALUSrcB = 10.
- R-type (0110011), MemReady = 1 -> FETCH, DECODE, EXECUTER (AluOp = 10), ALUWB (RegWrite = 1, InstrDone = 1), then FETCH. 4 cycles.
- lw (0000011), MemReady low for 2 cycles in FETCH and 3 cycles in MEMREAD -> IRWrite fires only on the ready cycle. MEMWB asserts RegWrite = 1 with ResultSrc = 01. 10 cycles total.
- sw (0100011), MemReady low for 2 cycles in MEMWRITE -> MemWrite = 1 for all 3 MEMWRITE cycles, AdrSrc = 1, RegWrite never asserted.
- beq (1100011): Zero = 1 -> PCWrite = 1 in BEQ with AluOp = 01. Zero = 0 -> PCWrite = 0. Both cases return to FETCH.
- Illegal op 1111111 -> IllegalOp pulse in DECODE, next state FETCH. jal (1101111) -> JAL asserts PCWrite = 1, then ALUWB asserts RegWrite = 1.
